// File: rtl/full_adder.sv
// full_adder: combinational 1-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one full_adder cell.
// Computes {carry_out_o, sum_o} = a_i + b_i + carry_in_i, one bit per clock, LSB first.
// Optional macro SERIAL_ADDER_OVERFLOW_EN adds a registered two's-complement overflow_o.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_in_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_out_o
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow_o
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sa_q, sa_d;
  logic [WIDTH-1:0]  sb_q, sb_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              c_q, c_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              fa_sum, fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic              ovf_q, ovf_d;
`endif

  full_adder u_full_adder (
    .a         (sa_q[0]),
    .b         (sb_q[0]),
    .carry_in  (c_q),
    .sum       (fa_sum),
    .carry_out (fa_cout)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          sa_d    = a_i;
          sb_d    = b_i;
          c_d     = carry_in_i;
          cnt_d   = '0;
        end
      end
      StRun: begin
        acc_d = {fa_sum, acc_q[WIDTH-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        c_d   = fa_cout;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
          // Result includes the bit produced on this final edge.
          sum_d   = acc_d;
          cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
          // c_q here is the carry into the MSB.
          ovf_d   = c_q ^ fa_cout;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready_o     = (state_q == StIdle);
  assign busy_o      = (state_q == StRun);
  assign done_o      = (state_q == StDone);
  assign sum_o       = sum_q;
  assign carry_out_o = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign overflow_o  = ovf_q;
`endif

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder that computes one bit per clock through a single instance of the team's full_adder (ports a, b, carry_in, sum, carry_out).
- Sits directly downstream of full_adder: consumes its sum and carry_out each cycle, registers the carry back into carry_in, and assembles the sum LSB-first.
- Trades area for latency. Used where one 1-bit adder cell must serve a multi-bit add.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when ready=1
- a  input  WIDTH  operand A; captured on the accepted start
- b  input  WIDTH  operand B; captured on the accepted start
- carry_in  input  1  initial carry; captured on the accepted start
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN only
- done  output  1  single-cycle pulse; result valid
- sum  output  WIDTH  result register
- carry_out  output  1  final carry register

Behaviour:
- Reset: rst_n low clears everything immediately, independent of clk.
  - State becomes IDLE, ready=1, busy=0, done=0, sum=0, carry_out=0.
  - Operand shift registers, carry flop and bit counter are cleared.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE to RUN: at the edge where start=1 and ready=1.
    - Load a and b into shift registers sa and sb.
    - Load carry_in into the carry flop c.
    - Clear the counter cnt (width clog2(WIDTH)+1).
  - RUN: each edge does the following.
    - full_adder inputs are sa[0], sb[0], c.
    - Its sum bit shifts into the MSB of an internal accumulator acc; acc shifts right.
    - sa and sb shift right, zero-filled.
    - c takes the full_adder carry_out.
    - cnt increments.
  - RUN to DONE: at the edge where cnt==WIDTH-1, i.e. the WIDTH-th RUN edge.
    - The same edge loads sum from the final accumulator value, including this edge's bit.
    - The same edge loads carry_out from the final carry.
  - DONE to IDLE: unconditionally at the next edge.
- Output timing:
  - done is high for exactly the one cycle spent in DONE.
  - If start is accepted at edge N, done is high between edges N+WIDTH and N+WIDTH+1.
  - busy is high between edges N and N+WIDTH.
- sum and carry_out change only on entry to DONE. They hold stable through the following IDLE and RUN until the next result.
- start is ignored in RUN and DONE, with no queueing.
  - If start is held high continuously, operations run back-to-back. Each operation is followed by one DONE cycle and then one IDLE cycle before the next start is accepted.
- a, b and carry_in may change freely after acceptance without affecting the running add.
- Arithmetic: {carry_out, sum} = a + b + carry_in, computed modulo 2^(WIDTH+1). It must match this exactly for all inputs.
- Reset mid-RUN aborts the add: no done pulse, and sum and carry_out are forced to 0.

Optional Feature:
- Macro: SERIAL_ADDER_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit) for two's-complement overflow.
  - overflow = carry into the MSB bit XOR the final carry. The carry into the MSB is the value of c sampled at the last RUN edge, before that edge's update.
  - overflow is registered and updates on the same edge as sum.
  - It resets to 0 and is forced to 0 on reset.
- Undefined: the overflow port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 asynchronously between edges -> outputs clear at once, before any clock edge; ready=1, busy=0, done=0, sum=8'h00, carry_out=0.
- WIDTH=8, a=8'h35, b=8'h4A, carry_in=0, start pulsed at edge N -> busy over N..N+8, done=1 only in cycle N+8, sum=8'h7F, carry_out=0; overflow=0 if enabled.
- a=8'hFF, b=8'h01, carry_in=0 -> sum=8'h00, carry_out=1, overflow=0. Then a=8'hFF, b=8'hFF, carry_in=1 -> sum=8'hFF, carry_out=1.
- a=8'h7F, b=8'h01, carry_in=0 -> sum=8'h80, carry_out=0, overflow=1 if enabled. Then a=8'h80, b=8'h80 -> sum=8'h00, carry_out=1, overflow=1.
- Change a, b and carry_in, and pulse start, during RUN -> ignored; result equals the originally captured add. With start held high, done pulses every WIDTH+2 cycles and sum updates only on done.
- Deassert rst_n at the 4th RUN cycle, then release -> immediate IDLE, no done pulse, sum=0. The next start with a=8'h12, b=8'h34 gives sum=8'h46 and carry_out=0.
